aes_sbox_sched: RTL and testbench

AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_sbox.sv | 35 +++
 rtl/aes_sbox_sched.sv | 150 +++++++++++++++
 tb/tb_aes_sbox_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and state encodings for the AES S-box scheduler.
package aes_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BLK_W         = 128;
  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned CNT_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_CPHR = 2'd2
  } state_t;

  // Which requester was granted most recently (round-robin history).
  typedef enum logic [1:0] {
    HIST_NONE = 2'd0,
    HIST_KEXP = 2'd1,
    HIST_CPHR = 2'd2
  } hist_t;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box applied to each byte of a 32-bit word.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      dout[8*i +: 8] = SBOX[din[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// Arbitrates one shared 32-bit S-box lookup between key expansion (one word)
// and cipher SubBytes (four words per block), round-robin on contention.
module aes_sbox_sched #(
  parameter bit P_CPHR_FIRST = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_kexp_req,
  input  logic [31:0]  i_kexp_wrd,
  output logic         o_kexp_ack,
  output logic         o_kexp_vld,
  output logic [31:0]  o_kexp_wrd,
  input  logic         i_cphr_req,
  input  logic [127:0] i_cphr_blk,
  output logic         o_cphr_ack,
  output logic         o_cphr_vld,
  output logic [127:0] o_cphr_blk,
  output logic         o_busy
);

  import aes_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLK - 1);

  state_t               state_q, state_d;
  hist_t                hist_q, hist_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLK_W-1:0]     in_q;
  logic [BLK_W-33:0]    acc_q;
  logic [WORD_W-1:0]    kexp_wrd_q;
  logic [BLK_W-1:0]     cphr_blk_q;
  logic                 kexp_vld_q, cphr_vld_q;

  logic                 kexp_ack_c, cphr_ack_c;
  logic                 kexp_done_c, cphr_done_c;
  logic                 pick_cphr_c;
  logic [WORD_W-1:0]    cphr_word_c, sbox_in_c, sbox_out_c;

  // Word-select mux: cipher words go MSW first as cnt advances.
  always_comb begin
    cphr_word_c = in_q[127:96];
    case (cnt_q)
      2'd0: cphr_word_c = in_q[127:96];
      2'd1: cphr_word_c = in_q[95:64];
      2'd2: cphr_word_c = in_q[63:32];
      2'd3: cphr_word_c = in_q[31:0];
      default: cphr_word_c = in_q[127:96];
    endcase
    sbox_in_c = (state_q == ST_CPHR) ? cphr_word_c : in_q[31:0];
  end

  aes_sbox u_sbox (
    .din  (sbox_in_c),
    .dout (sbox_out_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hist_q  <= HIST_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, arbitration and per-cycle control.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    kexp_ack_c  = 1'b0;
    cphr_ack_c  = 1'b0;
    kexp_done_c = 1'b0;
    cphr_done_c = 1'b0;
    pick_cphr_c = i_cphr_req;
    if (i_kexp_req && i_cphr_req) begin
      pick_cphr_c = (hist_q == HIST_NONE) ? P_CPHR_FIRST : (hist_q == HIST_KEXP);
    end
    case (state_q)
      ST_IDLE: begin
        if (i_kexp_req || i_cphr_req) begin
          if (pick_cphr_c) begin
            cphr_ack_c = 1'b1;
            state_d    = ST_CPHR;
            hist_d     = HIST_CPHR;
            cnt_d      = '0;
          end else begin
            kexp_ack_c = 1'b1;
            state_d    = ST_KEXP;
            hist_d     = HIST_KEXP;
          end
        end
      end
      ST_KEXP: begin
        kexp_done_c = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_CPHR: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) begin
          cphr_done_c = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_q       <= '0;
      acc_q      <= '0;
      kexp_wrd_q <= '0;
      cphr_blk_q <= '0;
      kexp_vld_q <= 1'b0;
      cphr_vld_q <= 1'b0;
    end else begin
      kexp_vld_q <= kexp_done_c;
      cphr_vld_q <= cphr_done_c;
      if (kexp_ack_c) begin
        in_q[31:0] <= i_kexp_wrd;
      end else if (cphr_ack_c) begin
        in_q <= i_cphr_blk;
      end
      if (state_q == ST_CPHR) begin
        acc_q <= {acc_q[63:0], sbox_out_c};
      end
      if (kexp_done_c) begin
        kexp_wrd_q <= sbox_out_c;
      end
      if (cphr_done_c) begin
        cphr_blk_q <= {acc_q, sbox_out_c};
      end
    end
  end

  // Reset forces every output low, including the combinational accepts.
  assign o_kexp_ack = kexp_ack_c & ~i_rst;
  assign o_cphr_ack = cphr_ack_c & ~i_rst;
  assign o_kexp_vld = kexp_vld_q & ~i_rst;
  assign o_cphr_vld = cphr_vld_q & ~i_rst;
  assign o_kexp_wrd = i_rst ? '0 : kexp_wrd_q;
  assign o_cphr_blk = i_rst ? '0 : cphr_blk_q;
  assign o_busy     = (state_q != ST_IDLE) & ~i_rst;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched: single jobs, collision, fairness, mid-job reset.
module tb_aes_sbox_sched;

  localparam logic [31:0]  K_IN  = 32'h00010253;
  localparam logic [31:0]  K_OUT = 32'h637c77ed;
  localparam logic [127:0] C_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk = 1'b0;
  logic         rst;
  logic         kexp_req, cphr_req;
  logic [31:0]  kexp_wrd_in;
  logic [127:0] cphr_blk_in;
  logic         kexp_ack, kexp_vld, cphr_ack, cphr_vld, busy;
  logic [31:0]  kexp_wrd_out;
  logic [127:0] cphr_blk_out;

  int errors = 0;
  int checks = 0;
  int grants[$];

  always #5 clk = ~clk;

  aes_sbox_sched #(.P_CPHR_FIRST(1'b0)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_kexp_req (kexp_req),
    .i_kexp_wrd (kexp_wrd_in),
    .o_kexp_ack (kexp_ack),
    .o_kexp_vld (kexp_vld),
    .o_kexp_wrd (kexp_wrd_out),
    .i_cphr_req (cphr_req),
    .i_cphr_blk (cphr_blk_in),
    .o_cphr_ack (cphr_ack),
    .o_cphr_vld (cphr_vld),
    .o_cphr_blk (cphr_blk_out),
    .o_busy     (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_kack"}, 128'(kexp_ack), '0);
    chk({tag, "_kvld"}, 128'(kexp_vld), '0);
    chk({tag, "_kwrd"}, 128'(kexp_wrd_out), '0);
    chk({tag, "_cack"}, 128'(cphr_ack), '0);
    chk({tag, "_cvld"}, 128'(cphr_vld), '0);
    chk({tag, "_cblk"}, cphr_blk_out, '0);
    chk({tag, "_busy"}, 128'(busy), '0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; kexp_req = 1'b0; cphr_req = 1'b0;
    kexp_wrd_in = '0; cphr_blk_in = '0;

    // Reset state
    next(); mid(); chk_zero("rst0");
    next(); mid(); chk_zero("rst1");

    // Single key request
    next(); rst = 1'b0; kexp_req = 1'b1; kexp_wrd_in = K_IN;
    mid();
    chk("k_ack_A", 128'(kexp_ack), 128'd1);
    chk("k_cack_A", 128'(cphr_ack), 128'd0);
    chk("k_busy_A", 128'(busy), 128'd0);
    next(); kexp_req = 1'b0; kexp_wrd_in = 32'hffffffff;
    mid();
    chk("k_busy_A1", 128'(busy), 128'd1);
    chk("k_vld_A1", 128'(kexp_vld), 128'd0);
    next(); mid();
    chk("k_vld_A2", 128'(kexp_vld), 128'd1);
    chk("k_wrd_A2", 128'(kexp_wrd_out), 128'(K_OUT));
    chk("k_busy_A2", 128'(busy), 128'd0);
    next(); mid();
    chk("k_vld_A3", 128'(kexp_vld), 128'd0);
    chk("k_hold_A3", 128'(kexp_wrd_out), 128'(K_OUT));

    // Single cipher request
    next(); cphr_req = 1'b1; cphr_blk_in = C_IN;
    mid();
    chk("c_ack_A", 128'(cphr_ack), 128'd1);
    chk("c_kack_A", 128'(kexp_ack), 128'd0);
    next(); cphr_req = 1'b0; cphr_blk_in = ~C_IN;
    for (int i = 1; i <= 4; i++) begin
      mid();
      chk($sformatf("c_busy_A%0d", i), 128'(busy), 128'd1);
      chk($sformatf("c_vld_A%0d", i), 128'(cphr_vld), 128'd0);
      next();
    end
    mid();
    chk("c_vld_A5", 128'(cphr_vld), 128'd1);
    chk("c_blk_A5", cphr_blk_out, C_OUT);
    chk("c_busy_A5", 128'(busy), 128'd0);
    chk("c_khold_A5", 128'(kexp_wrd_out), 128'(K_OUT));
    next(); mid();
    chk("c_vld_A6", 128'(cphr_vld), 128'd0);
    chk("c_hold_A6", cphr_blk_out, C_OUT);

    // Collision right after reset: key wins first
    next(); rst = 1'b1; mid();
    next(); rst = 1'b0; kexp_req = 1'b1; cphr_req = 1'b1;
    kexp_wrd_in = K_IN; cphr_blk_in = C_IN;
    mid();
    chk("col_kack_A", 128'(kexp_ack), 128'd1);
    chk("col_cack_A", 128'(cphr_ack), 128'd0);
    next(); kexp_req = 1'b0;
    mid();
    chk("col_cack_A1", 128'(cphr_ack), 128'd0);
    chk("col_busy_A1", 128'(busy), 128'd1);
    next(); mid();
    chk("col_kvld_A2", 128'(kexp_vld), 128'd1);
    chk("col_kwrd_A2", 128'(kexp_wrd_out), 128'(K_OUT));
    chk("col_cack_A2", 128'(cphr_ack), 128'd1);
    next(); cphr_req = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      mid();
      chk($sformatf("col_cvld_A%0d", i), 128'(cphr_vld), 128'd0);
      next();
    end
    mid();
    chk("col_cvld_A7", 128'(cphr_vld), 128'd1);
    chk("col_cblk_A7", cphr_blk_out, C_OUT);

    // Fairness with both requests held
    next(); rst = 1'b1; mid();
    next(); rst = 1'b0; kexp_req = 1'b1; cphr_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      mid();
      if (kexp_ack) grants.push_back(0);
      if (cphr_ack) grants.push_back(1);
      chk($sformatf("fair_excl_%0d", c), 128'(kexp_ack & cphr_ack), 128'd0);
      chk($sformatf("fair_busy_%0d", c), 128'((kexp_ack | cphr_ack) & busy), 128'd0);
      next();
    end
    kexp_req = 1'b0; cphr_req = 1'b0;
    chk("fair_count", 128'(grants.size() >= 4), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fair_grant_%0d", i),
          128'((i < grants.size()) ? grants[i] : 7), 128'(i % 2));
    end

    // Reset in the middle of a cipher job
    next(); rst = 1'b1; mid();
    next(); rst = 1'b0; cphr_req = 1'b1; cphr_blk_in = C_IN;
    mid();
    chk("rj_cack_A", 128'(cphr_ack), 128'd1);
    next(); mid();
    next(); rst = 1'b1;
    mid(); chk_zero("rj_A2");
    next();
    mid(); chk_zero("rj_A3");
    next(); rst = 1'b0;
    mid();
    chk("rj_reack_A4", 128'(cphr_ack), 128'd1);
    chk("rj_cvld_A4", 128'(cphr_vld), 128'd0);
    chk("rj_busy_A4", 128'(busy), 128'd0);
    next(); cphr_req = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      mid();
      chk($sformatf("rj_cvld_A%0d", i), 128'(cphr_vld), 128'd0);
      next();
    end
    mid();
    chk("rj_cvld_A9", 128'(cphr_vld), 128'd1);
    chk("rj_cblk_A9", cphr_blk_out, C_OUT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
